// File: rtl/brp_pkg.sv
// Shared types for the branch resolve path.
//   brp_state_t : resolve FSM state (RUN accepts traffic, FLUSH drops one wrong-path cycle)
//   PC_INC      : fall-through distance for a not-taken branch
//   brp_entry_t : one in-flight branch at the default 32-bit PC width
package brp_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } brp_state_t;

    localparam int PC_INC   = 4;
    localparam int BRP_PC_W = 32;

    typedef struct packed {
        logic [BRP_PC_W-1:0] pc;
        logic [BRP_PC_W-1:0] target;
        logic                taken;
    } brp_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// In-order queue of in-flight predicted branches.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write an entry at the tail (ignored when full)
//   pop      : retire the head entry (ignored when empty)
//   clear    : drop every entry; wins over push/pop in the same cycle
//   dout     : head entry (combinational read)
//   count    : occupancy; full/empty are derived from it
module brq_fifo
    import brp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * BRP_PC_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    input  logic                         clear,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolution end of the 2-bit predictor path. Predicted branches queue up in
// order; each resolve retires the oldest one, sends a one-cycle update to the
// predictor and, on a mispredict, flushes the queue and redirects fetch.
//   clk, rst                          : clock, synchronous active-high reset
//   pred_valid/taken/pc/target, ready : enqueue side from fetch
//   res_valid/taken/target            : actual outcome of the oldest branch
//   upd_valid/taken/pc                : registered update pulse to the predictor
//   flush, redirect_pc                : registered mispredict pulse and correct PC
//   mispredict_cnt                    : saturating mispredict count
//   inflight                          : queue occupancy
//   res_err                           : sticky, resolve seen with an empty queue
module branch_resolve_unit
    import brp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [PC_W-1:0]              pred_pc,
    input  logic [PC_W-1:0]              pred_target,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic [PC_W-1:0]              res_target,
    output logic                         upd_valid,
    output logic                         upd_taken,
    output logic [PC_W-1:0]              upd_pc,
    output logic                         flush,
    output logic [PC_W-1:0]              redirect_pc,
    output logic [CNT_W-1:0]             mispredict_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic                         res_err
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
    } entry_t;

    brp_state_t state;
    entry_t     wr_e, head;
    logic       full, empty;
    logic       run, do_enq, res_ok, mispred;

    assign run        = (state == RUN);
    // No same-cycle bypass: a full queue refuses even if the head pops now.
    assign pred_ready = !full && run;
    assign do_enq     = pred_valid && pred_ready;
    // Wrong-path resolves during FLUSH are dropped silently.
    assign res_ok     = res_valid && run && !empty;
    assign mispred    = res_ok && ((head.taken != res_taken) ||
                                   (res_taken && (head.target != res_target)));

    assign wr_e = '{pc: pred_pc, target: pred_target, taken: pred_taken};

    brq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_enq),
        .din   (wr_e),
        .pop   (res_ok),
        .clear (mispred),
        .dout  (head),
        .count (inflight),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
            upd_pc         <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            res_err        <= 1'b0;
        end else begin
            upd_valid <= res_ok;
            flush     <= mispred;
            if (res_ok) begin
                upd_taken <= res_taken;
                upd_pc    <= head.pc;
            end
            if (mispred) begin
                redirect_pc <= res_taken ? res_target : head.pc + PC_W'(PC_INC);
                if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 1'b1;
            end
            if (res_valid && run && empty) res_err <= 1'b1;
            // FLUSH lasts exactly one cycle.
            state <= mispred ? FLUSH : RUN;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 3;
    localparam int IW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid, pred_taken, pred_ready;
    logic [PC_W-1:0]  pred_pc, pred_target;
    logic             res_valid, res_taken;
    logic [PC_W-1:0]  res_target;
    logic             upd_valid, upd_taken, flush, res_err;
    logic [PC_W-1:0]  upd_pc, redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [IW-1:0]    inflight;

    branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .flush(flush), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt),
        .inflight(inflight), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of predicted branches plus a "flushing" flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          taken;
    } ent_t;

    ent_t        q[$];
    bit          m_fl;
    int          m_cnt;
    bit          m_err;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; pred_valid = 0; pred_taken = 0; pred_pc = '0; pred_target = '0;
        res_valid = 0; res_taken = 0; res_target = '0;
    endtask

    task automatic set_pred(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        pred_valid = 1; pred_pc = pc; pred_taken = tk; pred_target = tgt;
    endtask

    task automatic set_res(input bit tk, input logic [31:0] tgt);
        res_valid = 1; res_taken = tk; res_target = tgt;
    endtask

    // One clock: check the combinational ready, advance the model, check registered outputs.
    task automatic step();
        bit          acc, e_upd, e_ut, e_fl;
        logic [31:0] e_upc, e_rd;
        ent_t        h;
        e_upd = 0; e_ut = 0; e_fl = 0; e_upc = '0; e_rd = '0;
        #1;
        chk("pred_ready", {63'd0, pred_ready}, {63'd0, (!m_fl && q.size() < DEPTH)});
        if (rst) begin
            q.delete(); m_fl = 0; m_cnt = 0; m_err = 0;
        end else if (m_fl) begin
            m_fl = 0;
        end else begin
            acc = pred_valid && (q.size() < DEPTH);
            if (res_valid) begin
                if (q.size() == 0) m_err = 1;
                else begin
                    h = q.pop_front();
                    e_upd = 1; e_ut = res_taken; e_upc = h.pc;
                    if ((h.taken != res_taken) || (res_taken && h.tgt != res_target)) begin
                        e_fl = 1;
                        e_rd = res_taken ? res_target : h.pc + 32'd4;
                        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                        q.delete(); m_fl = 1; acc = 0;
                    end
                end
            end
            if (acc) q.push_back('{pred_pc, pred_target, pred_taken});
        end
        @(posedge clk); #1;
        chk("upd_valid", {63'd0, upd_valid}, {63'd0, e_upd});
        chk("flush", {63'd0, flush}, {63'd0, e_fl});
        chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_cnt));
        chk("inflight", 64'(inflight), 64'(q.size()));
        chk("res_err", {63'd0, res_err}, {63'd0, m_err});
        if (e_upd) begin
            chk("upd_pc", 64'(upd_pc), 64'(e_upc));
            chk("upd_taken", {63'd0, upd_taken}, {63'd0, e_ut});
        end
        if (e_fl) chk("redirect_pc", 64'(redirect_pc), 64'(e_rd));
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        q.delete(); m_fl = 0; m_cnt = 0; m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_cnt", 64'(mispredict_cnt), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_res_err", {63'd0, res_err}, 64'd0);
        chk("rst_pred_ready", {63'd0, pred_ready}, 64'd1);
        idle();

        // Correct taken prediction.
        set_pred(32'h100, 1, 32'h200); step();
        set_res(1, 32'h200); step();
        chk("t1_upd_pc", 64'(upd_pc), 64'h100);
        chk("t1_flush", {63'd0, flush}, 64'd0);

        // Predicted not-taken, actually taken.
        set_pred(32'h104, 0, 32'h0); step();
        set_res(1, 32'h300); step();
        chk("t2_redirect", 64'(redirect_pc), 64'h300);
        chk("t2_cnt", 64'(mispredict_cnt), 64'd1);
        step();

        // Predicted taken, actually not-taken: fall through to pc+4.
        set_pred(32'h108, 1, 32'h400); step();
        set_res(0, 32'h0); step();
        chk("t3_redirect", 64'(redirect_pc), 64'h10C);
        chk("t3_inflight", 64'(inflight), 64'd0);
        step();

        // Fill; a full queue rejects even when the head pops this cycle.
        for (int i = 0; i < DEPTH; i++) begin
            set_pred(32'h500 + 32'(i * 4), 1, 32'h600); step();
        end
        set_pred(32'h700, 1, 32'h600); set_res(1, 32'h600); step();
        chk("t4_inflight", 64'(inflight), 64'd3);
        for (int i = 0; i < 3; i++) begin
            set_res(1, 32'h600); step();
        end

        // Resolve with nothing queued.
        set_res(1, 32'h0); step();
        chk("t5_res_err", {63'd0, res_err}, 64'd1);
        rst = 1; step();
        chk("t5_rst_err", {63'd0, res_err}, 64'd0);

        // Mispredict with 3 queued and a same-cycle enqueue.
        for (int i = 0; i < 3; i++) begin
            set_pred(32'h800 + 32'(i * 4), 0, 32'h0); step();
        end
        set_pred(32'h900, 0, 32'h0); set_res(1, 32'hA00); step();
        chk("t6_inflight", 64'(inflight), 64'd0);
        step();

        // PC wrap on fall-through.
        set_pred(32'hFFFF_FFFC, 1, 32'h40); step();
        set_res(0, 32'h0); step();
        chk("t7_redirect_wrap", 64'(redirect_pc), 64'h0);
        step();

        // Drive the counter into saturation.
        for (int i = 0; i < 10; i++) begin
            set_pred(32'hC00, 0, 32'h0); step();
            set_res(1, 32'hD00); step();
            step();
        end
        chk("t8_cnt_sat", 64'(mispredict_cnt), 64'd7);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) rst = 1;
            if ($urandom_range(0, 1) == 1)
                set_pred({$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h300);
            if ($urandom_range(0, 2) != 0)
                set_res(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h300);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
